// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential divider: FSM state codes and default widths.
package seq_divider_pkg;

    localparam int DW_DEF = 16;  // dividend / quotient width
    localparam int VW_DEF = 8;   // divisor / remainder width
    localparam int CW_DEF = 5;   // iteration counter width, >= clog2(DW+1)

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, compare against the divisor and subtract when it fits.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int VW = VW_DEF
) (
    input  logic [VW-1:0] pr_i,      // partial remainder, always < divisor
    input  logic          dq_msb_i,  // next dividend bit to bring down
    input  logic [VW-1:0] dv_i,      // divisor
    output logic [VW-1:0] pr_next_o, // updated partial remainder, still < divisor
    output logic          q_bit_o    // quotient bit produced this iteration
);

    // t is VW+1 bits wide. When its top bit is set it already exceeds any VW-bit
    // divisor. The difference is always below the divisor, so the low VW bits
    // of a modular subtraction are exact.
    logic [VW:0] t;

    // Shift, compare, and conditionally subtract.
    always_comb begin
        t         = {pr_i, dq_msb_i};
        q_bit_o   = t[VW] | (t[VW-1:0] >= dv_i);
        pr_next_o = t[VW-1:0];
        if (q_bit_o) begin
            pr_next_o = t[VW-1:0] - dv_i;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient
// bit per clock. Results are held until the done pulse of the next operation.
//
// Handshake: start is sampled only in IDLE or DONE. A start seen there is
// accepted on that rising edge and the operands are latched. While busy is
// high, start is ignored. done is a one-cycle pulse on the cycle in which
// quotient/remainder/div_by_zero have just been updated.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,          // asynchronous, active low
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero,
    output logic [1:0]    dbg_state     // current FSM state, for observation only
);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [DW-1:0] dq_q,    dq_d;    // dividend, shifting out msb-first / quotient shifting in
    logic [VW-1:0] dv_q,    dv_d;
    logic [VW-1:0] pr_q,    pr_d;    // partial remainder
    logic [DW-1:0] quot_q,  quot_d;
    logic [VW-1:0] rem_q,   rem_d;
    logic          done_q,  done_d;
    logic          dbz_q,   dbz_d;

    logic [VW-1:0] pr_next;
    logic          q_bit;

    div_step #(.VW(VW)) u_step (
        .pr_i      (pr_q),
        .dq_msb_i  (dq_q[DW-1]),
        .dv_i      (dv_q),
        .pr_next_o (pr_next),
        .q_bit_o   (q_bit)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        dv_d    = dv_q;
        pr_d    = pr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dq_d  = dividend;
                    dv_d  = divisor;
                    pr_d  = '0;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        // Zero divisor: publish the defined result at once, skipping CALC.
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = dividend[VW-1:0];
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                pr_d  = pr_next;
                dq_d  = {dq_q[DW-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    // The last iteration's outputs go straight to the result registers.
                    state_d = S_DONE;
                    quot_d  = {dq_q[DW-2:0], q_bit};
                    rem_d   = pr_next;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            dv_q    <= '0;
            pr_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            dv_q    <= dv_d;
            pr_q    <= pr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == S_CALC);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized bench for seq_divider, checked against a plain
// arithmetic reference (a/b, a%b, with the defined zero-divisor result).
module tb_seq_divider;

    localparam int DW = 16;
    localparam int VW = 8;
    localparam int CW = 5;
    localparam int LAT_CALC = DW + 1;  // negedges from driving start to seeing done
    localparam int LAT_ZERO = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [1:0]    dbg_state;

    seq_divider #(.DW(DW), .VW(VW), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model: plain integer division with the defined zero-divisor result.
    task automatic ref_div(input int a, input int b,
                           output logic [DW-1:0] q, output logic [VW-1:0] r, output logic z);
        logic [DW-1:0] av;
        av = DW'(a);
        if (b == 0) begin
            q = '1;
            r = av[VW-1:0];
            z = 1'b1;
        end else begin
            q = DW'(a / b);
            r = VW'(a % b);
            z = 1'b0;
        end
    endtask

    // ---------------- driver tasks (entered at a negedge) ----------------
    // Wait for done, counting negedges; stops at a bound.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
    endtask

    // One division with a single-cycle start pulse; operands are scrambled after accept.
    task automatic do_div(input int a, input int b, output int lat, output logic busy_first);
        int n;
        start    = 1'b1;
        dividend = DW'(a);
        divisor  = VW'(b);
        @(negedge clk);
        start      = 1'b0;
        busy_first = busy;
        dividend   = DW'($urandom);
        divisor    = VW'($urandom);
        lat = 1;
        if (!done) begin
            wait_done(n);
            lat += n;
        end
    endtask

    // Scoreboard comparison of one completed operation.
    task automatic check_op(input string tag, input int a, input int b,
                            input int lat, input logic busy_first);
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic          ez;
        ref_div(a, b, eq, er, ez);
        check({tag, "_q"},    32'(quotient),    32'(eq));
        check({tag, "_r"},    32'(remainder),   32'(er));
        check({tag, "_dbz"},  32'(div_by_zero), 32'(ez));
        check({tag, "_lat"},  32'(lat),         32'((b == 0) ? LAT_ZERO : LAT_CALC));
        check({tag, "_busy"}, 32'(busy_first),  32'(b != 0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   lat;
        int   a, b;
        logic bf;
        logic saw_done;

        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_q",     32'(quotient),    0);
        check("rst_r",     32'(remainder),   0);
        check("rst_busy",  32'(busy),        0);
        check("rst_done",  32'(done),        0);
        check("rst_dbz",   32'(div_by_zero), 0);
        check("rst_state", 32'(dbg_state),   0);
        rst = 1'b1;
        @(negedge clk);

        // 1) basic division and one-cycle done pulse
        do_div(1000, 7, lat, bf);
        check_op("t1", 1000, 7, lat, bf);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 0);

        // 2) full-scale dividend
        do_div(65535, 255, lat, bf);
        check_op("t2a", 65535, 255, lat, bf);
        do_div(65535, 1, lat, bf);
        check_op("t2b", 65535, 1, lat, bf);
        @(negedge clk);

        // 3) zero divisor
        do_div(5, 0, lat, bf);
        check_op("t3", 5, 0, lat, bf);
        @(negedge clk);
        check("t3_done_pulse", 32'(done), 0);
        check("t3_busy",       32'(busy), 0);

        // 4) dividend < divisor, then a new start accepted directly from DONE
        do_div(100, 200, lat, bf);
        check_op("t4a", 100, 200, lat, bf);
        do_div(300, 16, lat, bf);
        check_op("t4b", 300, 16, lat, bf);
        @(negedge clk);

        // 5) start pulse while busy is ignored; old result held during CALC
        start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (4) begin @(negedge clk); lat++; end
        check("t5_hold_q", 32'(quotient),  18);
        check("t5_hold_r", 32'(remainder), 12);
        check("t5_busy",   32'(busy),      1);
        start = 1'b1; dividend = 16'd555; divisor = 8'd3;
        @(negedge clk);
        lat++;
        start = 1'b0;
        begin
            int n;
            wait_done(n);
            lat += n;
        end
        check_op("t5", 1000, 7, lat, 1'b1);
        @(negedge clk);

        // 6) reset during CALC aborts the operation
        start = 1'b1; dividend = 16'd40000; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_q",     32'(quotient),    0);
        check("t6_r",     32'(remainder),   0);
        check("t6_busy",  32'(busy),        0);
        check("t6_done",  32'(done),        0);
        check("t6_state", 32'(dbg_state),   0);
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("t6_no_done", 32'(saw_done), 0);
        do_div(12345, 99, lat, bf);
        check_op("t6b", 12345, 99, lat, bf);
        @(negedge clk);

        // 7) start held high: back-to-back divisions with a fixed done period
        start = 1'b1; dividend = 16'd50000; divisor = 8'd7;
        wait_done(lat);
        check_op("t7a", 50000, 7, lat, 1'b1);
        wait_done(lat);
        check("t7_period", 32'(lat), 32'(LAT_CALC));
        check("t7b_q", 32'(quotient),  32'(50000 / 7));
        check("t7b_r", 32'(remainder), 32'(50000 % 7));
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t7_idle", 32'(dbg_state), 0);

        // 8) randomized sweep with the reference model
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 19))
                0, 1:    b = 0;
                2:       b = 1;
                3:       b = 255;
                default: b = int'($urandom_range(1, 255));
            endcase
            if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, 300));
            else                           a = int'($urandom_range(0, 65535));
            do_div(a, b, lat, bf);
            check_op("rand", a, b, lat, bf);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
